// File: rtl/y86_decode_rf.sv
// Y86-64 decode stage: register-ID decode, reset-able register file, E/M/W forwarding,
// load-use detection and the D->E pipeline register with stall/bubble control.
module y86_decode_rf #(
   parameter int unsigned     XLEN        = 64,
   parameter int unsigned     NREG        = 15,
   parameter logic [XLEN-1:0] STACK_INIT  = '0,
   parameter logic [3:0]      BUBBLE_STAT = 4'h1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      D_stat,
   input  logic [3:0]      D_icode,
   input  logic [3:0]      D_ifun,
   input  logic [3:0]      D_rA,
   input  logic [3:0]      D_rB,
   input  logic [XLEN-1:0] D_valC,
   input  logic [XLEN-1:0] D_valP,
   input  logic [3:0]      e_dstE,
   input  logic [XLEN-1:0] e_valE,
   input  logic [3:0]      M_dstE,
   input  logic [XLEN-1:0] M_valE,
   input  logic [3:0]      M_dstM,
   input  logic [XLEN-1:0] m_valM,
   input  logic [3:0]      W_dstE,
   input  logic [3:0]      W_dstM,
   input  logic [XLEN-1:0] W_valE,
   input  logic [XLEN-1:0] W_valM,
   input  logic            E_stall,
   input  logic            E_bubble,
   output logic [3:0]      E_stat,
   output logic [3:0]      E_icode,
   output logic [3:0]      E_ifun,
   output logic [XLEN-1:0] E_valC,
   output logic [XLEN-1:0] E_valA,
   output logic [XLEN-1:0] E_valB,
   output logic [3:0]      E_dstE,
   output logic [3:0]      E_dstM,
   output logic [3:0]      E_srcA,
   output logic [3:0]      E_srcB,
   output logic            load_use,
   input  logic [3:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [3:0] RSP      = 4'h4;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   logic [XLEN-1:0] rf_q [NREG];

   logic [3:0]      src_a_c, src_b_c, dst_e_c, dst_m_c;
   logic [XLEN-1:0] raw_a_c, raw_b_c, val_a_c, val_b_c;

   logic [3:0]      ereg_stat_q, ereg_icode_q, ereg_ifun_q;
   logic [XLEN-1:0] ereg_valc_q, ereg_vala_q, ereg_valb_q;
   logic [3:0]      ereg_dste_q, ereg_dstm_q, ereg_srca_q, ereg_srcb_q;

   // Register ID decode
   always_comb begin
      src_a_c = RNONE;
      src_b_c = RNONE;
      dst_e_c = RNONE;
      dst_m_c = RNONE;
      case (D_icode)
         I_RRMOVQ: begin src_a_c = D_rA; dst_e_c = D_rB; end
         I_IRMOVQ: dst_e_c = D_rB;
         I_RMMOVQ: begin src_a_c = D_rA; src_b_c = D_rB; end
         I_MRMOVQ: begin src_b_c = D_rB; dst_m_c = D_rA; end
         I_OPQ:    begin src_a_c = D_rA; src_b_c = D_rB; dst_e_c = D_rB; end
         I_CALL:   begin src_b_c = RSP; dst_e_c = RSP; end
         I_RET:    begin src_a_c = RSP; src_b_c = RSP; dst_e_c = RSP; end
         I_PUSHQ:  begin src_a_c = D_rA; src_b_c = RSP; dst_e_c = RSP; end
         I_POPQ:   begin src_a_c = RSP; src_b_c = RSP; dst_e_c = RSP; dst_m_c = D_rA; end
         default:  ;
      endcase
   end

   // Register file: one write per register per edge, M port beats E port on a clash
   for (genvar g = 0; g < NREG; g++) begin : g_rf
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rf_q[g] <= (g == 4) ? STACK_INIT : '0;
         end else if (W_dstM == 4'(g)) begin
            rf_q[g] <= W_valM;
         end else if (W_dstE == 4'(g)) begin
            rf_q[g] <= W_valE;
         end
      end
   end

   // Raw reads; IDs outside the implemented range (including F) read as zero
   always_comb begin
      raw_a_c  = '0;
      raw_b_c  = '0;
      dbg_data = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (src_a_c == 4'(i))  raw_a_c  = rf_q[i];
         if (src_b_c == 4'(i))  raw_b_c  = rf_q[i];
         if (dbg_addr == 4'(i)) dbg_data = rf_q[i];
      end
   end

   // Forwarding: youngest stage first; a source of F never matches
   always_comb begin
      val_a_c = raw_a_c;
      if (D_icode == I_CALL) begin
         val_a_c = D_valP;
      end else if (src_a_c != RNONE) begin
         if      (e_dstE == src_a_c) val_a_c = e_valE;
         else if (M_dstE == src_a_c) val_a_c = M_valE;
         else if (M_dstM == src_a_c) val_a_c = m_valM;
         else if (W_dstM == src_a_c) val_a_c = W_valM;
         else if (W_dstE == src_a_c) val_a_c = W_valE;
      end
   end

   always_comb begin
      val_b_c = raw_b_c;
      if (src_b_c != RNONE) begin
         if      (e_dstE == src_b_c) val_b_c = e_valE;
         else if (M_dstE == src_b_c) val_b_c = M_valE;
         else if (M_dstM == src_b_c) val_b_c = m_valM;
         else if (W_dstM == src_b_c) val_b_c = W_valM;
         else if (W_dstE == src_b_c) val_b_c = W_valE;
      end
   end

   // A load in E whose destination is a source of the instruction in decode
   always_comb begin
      load_use = 1'b0;
      if ((ereg_icode_q == I_MRMOVQ || ereg_icode_q == I_POPQ) && ereg_dstm_q != RNONE &&
          (ereg_dstm_q == src_a_c || ereg_dstm_q == src_b_c)) begin
         load_use = 1'b1;
      end
   end

   // D->E pipeline register: reset, then bubble, then stall
   always_ff @(posedge clk) begin
      if (!rst_n || E_bubble) begin
         ereg_stat_q  <= BUBBLE_STAT;
         ereg_icode_q <= I_NOP;
         ereg_ifun_q  <= 4'h0;
         ereg_valc_q  <= '0;
         ereg_vala_q  <= '0;
         ereg_valb_q  <= '0;
         ereg_dste_q  <= RNONE;
         ereg_dstm_q  <= RNONE;
         ereg_srca_q  <= RNONE;
         ereg_srcb_q  <= RNONE;
      end else if (!E_stall) begin
         ereg_stat_q  <= D_stat;
         ereg_icode_q <= D_icode;
         ereg_ifun_q  <= D_ifun;
         ereg_valc_q  <= D_valC;
         ereg_vala_q  <= val_a_c;
         ereg_valb_q  <= val_b_c;
         ereg_dste_q  <= dst_e_c;
         ereg_dstm_q  <= dst_m_c;
         ereg_srca_q  <= src_a_c;
         ereg_srcb_q  <= src_b_c;
      end
   end

   assign E_stat  = ereg_stat_q;
   assign E_icode = ereg_icode_q;
   assign E_ifun  = ereg_ifun_q;
   assign E_valC  = ereg_valc_q;
   assign E_valA  = ereg_vala_q;
   assign E_valB  = ereg_valb_q;
   assign E_dstE  = ereg_dste_q;
   assign E_dstM  = ereg_dstm_q;
   assign E_srcA  = ereg_srca_q;
   assign E_srcB  = ereg_srcb_q;

endmodule

// File: tb/tb_y86_decode_rf.sv
// Directed bench for y86_decode_rf: a 15-register instance plus an 8-register instance
// sharing all inputs, so implemented-range behaviour can be contrasted directly.
module tb_y86_decode_rf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic        E_stall, E_bubble;
   logic [3:0]  dbg_addr;

   logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB, dbg_data;
   logic        load_use;

   logic [3:0]  E_stat8, E_icode8, E_ifun8, E_dstE8, E_dstM8, E_srcA8, E_srcB8;
   logic [63:0] E_valC8, E_valA8, E_valB8, dbg_data8;
   logic        load_use8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   y86_decode_rf #(.XLEN(64), .NREG(15), .STACK_INIT(64'h100), .BUBBLE_STAT(4'h1)) dut (
      .clk(clk), .rst_n(rst_n),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .E_stall(E_stall), .E_bubble(E_bubble),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .load_use(load_use), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   y86_decode_rf #(.XLEN(64), .NREG(8), .STACK_INIT(64'h200), .BUBBLE_STAT(4'h1)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .E_stall(E_stall), .E_bubble(E_bubble),
      .E_stat(E_stat8), .E_icode(E_icode8), .E_ifun(E_ifun8),
      .E_valC(E_valC8), .E_valA(E_valA8), .E_valB(E_valB8),
      .E_dstE(E_dstE8), .E_dstM(E_dstM8), .E_srcA(E_srcA8), .E_srcB(E_srcB8),
      .load_use(load_use8), .dbg_addr(dbg_addr), .dbg_data(dbg_data8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      D_stat = 4'h1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
      D_valC = '0; D_valP = '0;
      e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
      E_stall = 1'b0; E_bubble = 1'b0; dbg_addr = 4'hF;
   endtask

   task automatic test_reset();
      logic [63:0] exp;
      idle_inputs();
      rst_n = 1'b0;
      W_dstE = 4'h3; W_valE = 64'hABCD;
      tick();
      for (int a = 0; a < 16; a++) begin
         dbg_addr = 4'(a);
         #1;
         exp = (a == 4) ? 64'h100 : 64'h0;
         checks++;
         if (dbg_data !== exp) begin
            failures++;
            $display("FAIL reset_dbg[%0d] got=%h exp=%h", a, dbg_data, exp);
         end
      end
      dbg_addr = 4'h4;
      #1;
      checks++;
      if (dbg_data8 !== 64'h200) begin
         failures++; $display("FAIL reset_dbg8[4] got=%h exp=%h", dbg_data8, 64'h200);
      end
      checks++;
      if (E_icode !== 4'h1 || E_stat !== 4'h1 || E_dstE !== 4'hF || E_dstM !== 4'hF) begin
         failures++;
         $display("FAIL reset_ereg icode=%h stat=%h dstE=%h dstM=%h exp=1/1/F/F",
                  E_icode, E_stat, E_dstE, E_dstM);
      end
      checks++;
      if (E_valA !== 64'h0 || E_valB !== 64'h0 || E_valC !== 64'h0 || E_srcA !== 4'hF) begin
         failures++;
         $display("FAIL reset_evals valA=%h valB=%h valC=%h srcA=%h exp=0/0/0/F",
                  E_valA, E_valB, E_valC, E_srcA);
      end
      W_dstE = 4'hF; W_valE = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_write_forward();
      D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h1;
      W_dstE = 4'h3; W_valE = 64'h55;
      dbg_addr = 4'h3;
      #1;
      checks++;
      if (dbg_data !== 64'h0) begin
         failures++; $display("FAIL wf_raw_before got=%h exp=%h", dbg_data, 64'h0);
      end
      tick();
      checks++;
      if (E_valA !== 64'h55) begin
         failures++; $display("FAIL wf_valA got=%h exp=%h", E_valA, 64'h55);
      end
      checks++;
      if (E_icode !== 4'h2 || E_srcA !== 4'h3 || E_dstE !== 4'h1 || E_srcB !== 4'hF) begin
         failures++;
         $display("FAIL wf_ids icode=%h srcA=%h dstE=%h srcB=%h exp=2/3/1/F",
                  E_icode, E_srcA, E_dstE, E_srcB);
      end
      checks++;
      if (dbg_data !== 64'h55) begin
         failures++; $display("FAIL wf_raw_after got=%h exp=%h", dbg_data, 64'h55);
      end
      W_dstE = 4'hF;
   endtask

   task automatic test_forward_priority();
      D_icode = 4'h6; D_ifun = 4'h1; D_rA = 4'h2; D_rB = 4'h2;
      e_dstE = 4'h2; e_valE = 64'h1;
      M_dstE = 4'h2; M_valE = 64'h2;
      W_dstE = 4'h2; W_valE = 64'h3;
      tick();
      checks++;
      if (E_valA !== 64'h1 || E_valB !== 64'h1) begin
         failures++; $display("FAIL fp_e valA=%h valB=%h exp=1/1", E_valA, E_valB);
      end
      checks++;
      if (E_ifun !== 4'h1) begin
         failures++; $display("FAIL fp_ifun got=%h exp=%h", E_ifun, 4'h1);
      end
      e_dstE = 4'hF;
      M_dstM = 4'h2; m_valM = 64'h7;
      tick();
      checks++;
      if (E_valA !== 64'h2) begin
         failures++; $display("FAIL fp_mE got=%h exp=%h", E_valA, 64'h2);
      end
      M_dstE = 4'hF;
      W_dstM = 4'h2; W_valM = 64'h8; W_valE = 64'hA;
      tick();
      checks++;
      if (E_valA !== 64'h7) begin
         failures++; $display("FAIL fp_mM got=%h exp=%h", E_valA, 64'h7);
      end
      M_dstM = 4'hF;
      W_valM = 64'h9;
      tick();
      checks++;
      if (E_valA !== 64'h9) begin
         failures++; $display("FAIL fp_wM got=%h exp=%h", E_valA, 64'h9);
      end
      W_dstM = 4'hF; W_dstE = 4'hF;
      dbg_addr = 4'h2;
      tick();
      checks++;
      if (E_valA !== 64'h9 || dbg_data !== 64'h9) begin
         failures++; $display("FAIL fp_raw valA=%h dbg=%h exp=9/9", E_valA, dbg_data);
      end
      D_ifun = 4'h0;
   endtask

   task automatic test_no_false_f();
      D_icode = 4'h1; D_rA = 4'hF; D_rB = 4'hF;
      e_dstE = 4'hF; e_valE = 64'hDEAD;
      M_dstE = 4'hF; M_valE = 64'hBEEF;
      W_dstM = 4'hF; W_valM = 64'hCAFE;
      tick();
      checks++;
      if (E_valA !== 64'h0 || E_valB !== 64'h0) begin
         failures++; $display("FAIL nof_vals valA=%h valB=%h exp=0/0", E_valA, E_valB);
      end
      checks++;
      if (E_icode !== 4'h1 || E_srcA !== 4'hF || E_dstE !== 4'hF) begin
         failures++;
         $display("FAIL nof_ids icode=%h srcA=%h dstE=%h exp=1/F/F", E_icode, E_srcA, E_dstE);
      end
      e_valE = '0; M_valE = '0; W_valM = '0;
   endtask

   task automatic test_load_use();
      D_icode = 4'h5; D_rA = 4'h5; D_rB = 4'hF;
      tick();
      checks++;
      if (E_icode !== 4'h5 || E_dstM !== 4'h5) begin
         failures++; $display("FAIL lu_load icode=%h dstM=%h exp=5/5", E_icode, E_dstM);
      end
      D_icode = 4'h6; D_rA = 4'h5; D_rB = 4'h0;
      #1;
      checks++;
      if (load_use !== 1'b1) begin
         failures++; $display("FAIL lu_srcA got=%b exp=1", load_use);
      end
      D_rA = 4'h1; D_rB = 4'h0;
      #1;
      checks++;
      if (load_use !== 1'b0) begin
         failures++; $display("FAIL lu_none got=%b exp=0", load_use);
      end
      D_rB = 4'h5;
      #1;
      checks++;
      if (load_use !== 1'b1) begin
         failures++; $display("FAIL lu_srcB got=%b exp=1", load_use);
      end
      E_bubble = 1'b1; E_stall = 1'b1;
      tick();
      checks++;
      if (E_icode !== 4'h1 || E_stat !== 4'h1 || E_dstM !== 4'hF || load_use !== 1'b0) begin
         failures++;
         $display("FAIL lu_bubble icode=%h stat=%h dstM=%h lu=%b exp=1/1/F/0",
                  E_icode, E_stat, E_dstM, load_use);
      end
      E_bubble = 1'b0; E_stall = 1'b0;
   endtask

   task automatic test_stall();
      D_stat = 4'h2; D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h7; D_valC = 64'h1234;
      tick();
      checks++;
      if (E_icode !== 4'h3 || E_stat !== 4'h2 || E_valC !== 64'h1234 || E_dstE !== 4'h7) begin
         failures++;
         $display("FAIL st_load icode=%h stat=%h valC=%h dstE=%h exp=3/2/1234/7",
                  E_icode, E_stat, E_valC, E_dstE);
      end
      E_stall = 1'b1;
      D_stat = 4'h1; D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2; D_valC = 64'h9999;
      tick();
      tick();
      checks++;
      if (E_icode !== 4'h3 || E_stat !== 4'h2 || E_valC !== 64'h1234 ||
          E_dstE !== 4'h7 || E_srcA !== 4'hF) begin
         failures++;
         $display("FAIL st_hold icode=%h stat=%h valC=%h dstE=%h srcA=%h exp=3/2/1234/7/F",
                  E_icode, E_stat, E_valC, E_dstE, E_srcA);
      end
      E_stall = 1'b0;
      D_icode = 4'h1; D_rA = 4'hF; D_rB = 4'hF; D_valC = '0;
   endtask

   task automatic test_write_conflict();
      W_dstE = 4'h4; W_valE = 64'h10;
      W_dstM = 4'h4; W_valM = 64'h20;
      dbg_addr = 4'h4;
      tick();
      checks++;
      if (dbg_data !== 64'h20 || dbg_data8 !== 64'h20) begin
         failures++;
         $display("FAIL wc_rsp dbg=%h dbg8=%h exp=20/20", dbg_data, dbg_data8);
      end
      W_dstM = 4'hF;
      W_dstE = 4'h9; W_valE = 64'h99;
      dbg_addr = 4'h9;
      tick();
      checks++;
      if (dbg_data !== 64'h99) begin
         failures++; $display("FAIL wc_r9_nreg15 got=%h exp=%h", dbg_data, 64'h99);
      end
      checks++;
      if (dbg_data8 !== 64'h0) begin
         failures++; $display("FAIL wc_r9_nreg8 got=%h exp=%h", dbg_data8, 64'h0);
      end
      W_dstE = 4'hF;
   endtask

   task automatic test_call_valp();
      D_icode = 4'h8; D_rA = 4'hF; D_rB = 4'hF; D_valP = 64'h4242;
      tick();
      checks++;
      if (E_valA !== 64'h4242 || E_valB !== 64'h20) begin
         failures++; $display("FAIL call_vals valA=%h valB=%h exp=4242/20", E_valA, E_valB);
      end
      checks++;
      if (E_dstE !== 4'h4 || E_srcB !== 4'h4 || E_srcA !== 4'hF) begin
         failures++;
         $display("FAIL call_ids dstE=%h srcB=%h srcA=%h exp=4/4/F", E_dstE, E_srcB, E_srcA);
      end
      D_icode = 4'h1; D_valP = '0;
   endtask

   task automatic test_reset_mid();
      D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h3;
      W_dstE = 4'h3; W_valE = 64'hFFFF;
      rst_n = 1'b0;
      dbg_addr = 4'h3;
      tick();
      checks++;
      if (dbg_data !== 64'h0) begin
         failures++; $display("FAIL rm_r3 got=%h exp=%h", dbg_data, 64'h0);
      end
      dbg_addr = 4'h4;
      #1;
      checks++;
      if (dbg_data !== 64'h100 || E_icode !== 4'h1 || E_valA !== 64'h0) begin
         failures++;
         $display("FAIL rm_state r4=%h icode=%h valA=%h exp=100/1/0", dbg_data, E_icode, E_valA);
      end
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_write_forward();
      test_forward_priority();
      test_no_false_f();
      test_load_use();
      test_stall();
      test_write_conflict();
      test_call_valp();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
